// File: rtl/cnn_window_gen.sv
// 3x3 sliding-window generator: raster pixel stream in, one complete window per
// accepted bottom-right pixel out, with valid/ready on both sides.
module cnn_window_gen #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pixel,
  input  logic              in_sof,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [DATA_W-1:0] win0,
  output logic [DATA_W-1:0] win1,
  output logic [DATA_W-1:0] win2,
  output logic [DATA_W-1:0] win3,
  output logic [DATA_W-1:0] win4,
  output logic [DATA_W-1:0] win5,
  output logic [DATA_W-1:0] win6,
  output logic [DATA_W-1:0] win7,
  output logic [DATA_W-1:0] win8,
  output logic              win_last
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic          acc, emit, frame_end;

  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb2 [IMG_W];
  logic [DATA_W-1:0] lb1_rd, lb2_rd;

  logic [8:0][DATA_W-1:0] sr, sr_nxt, win_q;

  assign in_ready = ~win_valid | win_ready;
  assign acc      = in_valid & in_ready;

  // SOF forces this pixel to (0,0) so a truncated frame resyncs immediately
  assign cur_col = in_sof ? '0 : col;
  assign cur_row = in_sof ? '0 : row;

  assign lb1_rd = lb1[cur_col];
  assign lb2_rd = lb2[cur_col];

  assign emit      = acc && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  assign frame_end = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

  // Each window row drops its left pixel; the right column is {lb2, lb1, pixel}
  for (genvar r = 0; r < 3; r++) begin : g_row
    assign sr_nxt[3*r]   = sr[3*r+1];
    assign sr_nxt[3*r+1] = sr[3*r+2];
  end
  assign sr_nxt[2] = lb2_rd;
  assign sr_nxt[5] = lb1_rd;
  assign sr_nxt[8] = in_pixel;

  // Line buffers are plain RAM; rows 0/1 never emit, so stale contents are harmless
  always_ff @(posedge clk) begin
    if (acc) begin
      lb2[cur_col] <= lb1_rd;
      lb1[cur_col] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      sr        <= '0;
      win_q     <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else begin
      if (acc) begin
        sr <= sr_nxt;
        if (cur_col == COL_LAST) begin
          col <= '0;
          row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end
      end
      if (emit) begin
        win_q     <= sr_nxt;
        win_valid <= 1'b1;
        win_last  <= frame_end;
      end else if (win_valid && win_ready) begin
        win_valid <= 1'b0;
        win_last  <= 1'b0;
      end
    end
  end

  assign win0 = win_q[0];
  assign win1 = win_q[1];
  assign win2 = win_q[2];
  assign win3 = win_q[3];
  assign win4 = win_q[4];
  assign win5 = win_q[5];
  assign win6 = win_q[6];
  assign win7 = win_q[7];
  assign win8 = win_q[8];

endmodule

// File: tb/tb_cnn_window_gen.sv
// Scoreboard bench for cnn_window_gen: a 4x4 instance for directed cases and a
// 6x6 instance for randomized flow control, checked against a full-frame model.
module tb_cnn_window_gen;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       win_ready = 1'b1;
  logic [7:0] in_pixel = '0;
  logic       sel = 1'b0;

  logic a_iv, b_iv, a_ir, b_ir, a_wv, b_wv, a_wl, b_wl;
  logic [8:0][7:0] a_win, b_win;
  logic cur_ir, cur_wv, cur_wl;
  logic [8:0][7:0] cur_win;

  int total = 0;
  int bad = 0;

  int mw = 4, mh = 4, mr = 0, mc = 0;
  logic [7:0]  img [6][6];
  logic [72:0] exp_q[$], log_q[$], ref_q[$];
  logic [72:0] mon_e, hold_w;
  logic [8:0][7:0] mw_win;

  logic rnd_on = 1'b0;
  logic stall_arm = 1'b0;
  int   stall_left = 0;

  always #5 clk = ~clk;

  assign a_iv    = in_valid & ~sel;
  assign b_iv    = in_valid & sel;
  assign cur_ir  = sel ? b_ir : a_ir;
  assign cur_wv  = sel ? b_wv : a_wv;
  assign cur_wl  = sel ? b_wl : a_wl;
  assign cur_win = sel ? b_win : a_win;

  cnn_window_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir),
    .in_pixel(in_pixel), .in_sof(in_sof), .win_valid(a_wv), .win_ready(win_ready),
    .win0(a_win[0]), .win1(a_win[1]), .win2(a_win[2]), .win3(a_win[3]),
    .win4(a_win[4]), .win5(a_win[5]), .win6(a_win[6]), .win7(a_win[7]),
    .win8(a_win[8]), .win_last(a_wl));

  cnn_window_gen #(.IMG_W(6), .IMG_H(6), .DATA_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir),
    .in_pixel(in_pixel), .in_sof(in_sof), .win_valid(b_wv), .win_ready(win_ready),
    .win0(b_win[0]), .win1(b_win[1]), .win2(b_win[2]), .win3(b_win[3]),
    .win4(b_win[4]), .win5(b_win[5]), .win6(b_win[6]), .win7(b_win[7]),
    .win8(b_win[8]), .win_last(b_wl));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor + reference model; everything sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      mr = 0;
      mc = 0;
      exp_q.delete();
    end else begin
      if (stall_left > 0) begin
        chk("stall_in_ready", cur_ir, 0);
        chk("stall_hold", {cur_wv, cur_wl, cur_win}, {1'b1, hold_w});
      end
      if (cur_wv && win_ready) begin
        if (exp_q.size() == 0) chk("extra_win", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("win", {cur_wl, cur_win}, mon_e);
        end
        log_q.push_back({cur_wl, cur_win});
      end
      if (in_valid && cur_ir) begin
        if (in_sof) begin mr = 0; mc = 0; end
        img[mr][mc] = in_pixel;
        if (mr >= 2 && mc >= 2) begin
          for (int i = 0; i < 9; i++) mw_win[i] = img[mr-2+i/3][mc-2+i%3];
          exp_q.push_back({(mr == mh-1) && (mc == mw-1), mw_win});
        end
        if (mc == mw-1) begin
          mc = 0;
          mr = (mr == mh-1) ? 0 : mr + 1;
        end else mc++;
      end
    end
  end

  // Sole driver of win_ready: random, one-shot 5-cycle stall, or always ready
  initial forever begin
    @(posedge clk); #1;
    if (rnd_on) win_ready = 1'($urandom_range(0, 1));
    else if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) win_ready = 1'b1;
    end else if (stall_arm && cur_wv) begin
      stall_arm  = 1'b0;
      stall_left = 5;
      win_ready  = 1'b0;
      hold_w     = {cur_wl, cur_win};
    end else win_ready = 1'b1;
  end

  task automatic send(input logic [7:0] p, input logic sof);
    int n = 0;
    in_pixel = p; in_sof = sof; in_valid = 1'b1;
    @(negedge clk);
    while (!cur_ir && n < 200) begin @(negedge clk); n++; end
    if (!cur_ir) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic frame(input int base, input logic sof_first, input int npix);
    for (int i = 1; i <= npix; i++) send(8'(base + i), (i == 1) && sof_first);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || cur_wv) && n < 500) begin @(negedge clk); n++; end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 chk("reset_drops_valid", cur_wv, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic cmp_ref(input string tag);
    chk({tag, "_count"}, log_q.size(), ref_q.size());
    for (int i = 0; i < ref_q.size() && i < log_q.size(); i++) chk(tag, log_q[i], ref_q[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int nlast;
    #2;
    chk("rst_win_valid", {a_wv, b_wv}, 0);
    chk("rst_win_last", {a_wl, b_wl}, 0);
    chk("rst_win_data", a_win, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("rst_in_ready", {a_ir, b_ir}, 2'b11);

    // 1: back-to-back 4x4, latency and window contents
    log_q.delete();
    frame(0, 1, 10);
    chk("pre_first_valid", cur_wv, 0);
    send(8'd11, 1'b0);
    chk("first_valid_latency", cur_wv, 1);
    chk("first_win", {cur_wl, cur_win},
        {1'b0, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1});
    for (int i = 12; i <= 16; i++) send(8'(i), 1'b0);
    drain();
    chk("t1_count", log_q.size(), 4);
    for (int i = 0; i < 3 && i < log_q.size(); i++) chk("t1_last_low", log_q[i][72], 0);
    if (log_q.size() == 4) begin
      chk("t1_w1", log_q[1], {1'b0, 8'd12, 8'd11, 8'd10, 8'd8, 8'd7, 8'd6, 8'd4, 8'd3, 8'd2});
      chk("t1_w2", log_q[2], {1'b0, 8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5});
      chk("t1_w3", log_q[3], {1'b1, 8'd16, 8'd15, 8'd14, 8'd12, 8'd11, 8'd10, 8'd8, 8'd7, 8'd6});
    end
    ref_q = log_q;

    // 2: downstream stall on the first window
    log_q.delete();
    stall_arm = 1'b1;
    frame(0, 1, 16);
    drain();
    chk("t2_stall_taken", stall_arm, 0);
    cmp_ref("t2_seq");

    // 3: two frames back-to-back, second offset by 100
    log_q.delete();
    frame(0, 1, 16);
    frame(100, 1, 16);
    drain();
    chk("t3_count", log_q.size(), 8);
    if (log_q.size() >= 5)
      chk("t3_f2_first", log_q[4],
          {1'b0, 8'd111, 8'd110, 8'd109, 8'd107, 8'd106, 8'd105, 8'd103, 8'd102, 8'd101});

    // 4: truncated frame then SOF resync
    log_q.delete();
    frame(0, 1, 6);
    frame(0, 1, 16);
    drain();
    cmp_ref("t4_seq");

    // 5: reset mid-frame, restart without SOF
    log_q.delete();
    frame(0, 1, 10);
    pulse_reset();
    frame(0, 0, 16);
    drain();
    cmp_ref("t5_seq");

    // 6: 6x6 instance, random gaps and random backpressure, three frames
    sel = 1'b1; mw = 6; mh = 6;
    pulse_reset();
    log_q.delete();
    rnd_on = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 36; i++) begin
        while ($urandom_range(0, 1) == 1) @(posedge clk);
        #1 send(8'($urandom_range(0, 255)), i == 0);
      end
    rnd_on = 1'b0;
    drain();
    chk("t6_count", log_q.size(), 48);
    nlast = 0;
    foreach (log_q[i]) if (log_q[i][72]) nlast++;
    chk("t6_last_count", nlast, 3);
    if (log_q.size() == 48)
      chk("t6_last_pos", {log_q[15][72], log_q[31][72], log_q[47][72]}, 3'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
